id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   Decode-to-execute pipeline register for the 5-stage RV32 core.
//   - Captures decoded operands and control each cycle.
//   - Detects load-use hazards, stalls fetch/decode and inserts a one-cycle bubble.
//   - Applies the write-back bypass on register-file read data.
//   - Its outputs (rs1_exe, rs2_exe) drive the EX-stage forwarding unit.
// PARAMETERS
//   XLEN    32  datapath width
//   CTRL_W  8   width of the opaque EX/MEM/WB control bundle
// PORTS
//   clk                 in   1       rising-edge clock
//   reset               in   1       asynchronous, active-low reset (0 = in reset)
//   d_valid             in   1       decode slot holds a real instruction
//   d_pc                in   XLEN    decode PC
//   d_rs1, d_rs2, d_rd  in   5       decoded register indices
//   d_uses_rs1/2        in   1       instruction actually reads rs1 / rs2
//   d_rs1_data/2_data   in   XLEN    register-file read data
//   d_imm               in   XLEN    decoded immediate
//   d_reg_write_enable  in   1       instruction writes rd
//   d_mem_read          in   1       instruction is a load
//   d_ctrl              in   CTRL_W  remaining control bundle
//   flush               in   1       EX redirect (taken branch/jump); kill decode slot
//   w_reg_write_enable  in   1       WB stage writes the register file this cycle
//   w_dest_reg          in   5       WB destination
//   w_data              in   XLEN    WB write data
//   stall_fd            out  1       hold PC and the IF/ID register this cycle
//   e_valid             out  1       EX slot valid
//   e_pc, e_imm         out  XLEN    registered PC / immediate
//   rs1_exe, rs2_exe    out  5       registered source indices (to forwarding unit)
//   e_rd                out  5       registered destination
//   e_rs1_data/2_data   out  XLEN    registered operands, WB-bypassed
//   e_reg_write_enable  out  1       registered write enable
//   e_mem_read          out  1       registered load flag
//   e_ctrl              out  CTRL_W  registered control bundle
//   load_use_stalls     out  16      saturating count of load-use bubbles
// BEHAVIOUR
//   - hazard (combinational), all of:
//       d_valid & e_valid & e_mem_read & (e_rd != 0) &
//       ((d_uses_rs1 & d_rs1 == e_rd) | (d_uses_rs2 & d_rs2 == e_rd))
//   - stall_fd = hazard & ~flush. Combinational, same cycle; no registered latency.
//   - Priority per rising edge is flush > hazard > advance.
//   - Bubble, inserted on flush or hazard:
//       e_valid, e_reg_write_enable, e_mem_read, rs1_exe, rs2_exe, e_rd <= 0
//       e_ctrl <= 0
//       e_pc, e_imm and operand data hold their previous value.
//   - Advance: every e_* output <= its d_* counterpart, with latency 1.
//       If d_valid = 0, the control bits (write enable, mem read, e_ctrl) and all
//       indices are forced to 0.
//   - WB bypass, applied per source:
//       e_rs1_data <= (w_reg_write_enable & w_dest_reg != 0 & w_dest_reg == d_rs1)
//                     ? w_data : d_rs1_data
//       e_rs2_data uses the same rule with d_rs2.
//   - Register x0 never matches a hazard or bypass, including when x0 is written.
//   - A load-use hazard costs exactly one bubble:
//       - the next cycle, e_mem_read = 0, so the hazard clears;
//       - the dependent instruction then takes its operand from WB through the
//         forwarding unit (select 01).
//   - load_use_stalls increments by 1 on each edge that inserts a hazard bubble with
//     flush = 0. It saturates at 16'hFFFF. Flush-only bubbles do not count.
//   - Reset (reset = 0): all outputs clear asynchronously to 0, including the counter.
//       - stall_fd = 0, because e_valid = 0.
//       - Reset asserted mid-stall drops the bubble; the first edge after release
//         is a normal advance.
// TESTING
//   1. Reset: drive reset=0 mid-stream -> every output reads 0 immediately (no clock
//      edge needed), stall_fd=0.
//   2. Load-use: lw x5 in EX (e_mem_read=1, e_rd=5); add with d_rs1=5, d_uses_rs1=1
//      -> stall_fd=1; next edge gives e_valid=0 and load_use_stalls=1; the edge after
//      gives rs1_exe=5.
//   3. No false stall: same as 2 with d_uses_rs1=0, or e_rd=0, or e_mem_read=0
//      -> stall_fd=0, instruction advances in 1 cycle.
//   4. Flush during hazard: setup of 2 plus flush=1 -> stall_fd=0; next edge gives
//      e_valid=0, e_ctrl=0, counter unchanged.
//   5. WB bypass: w_reg_write_enable=1, w_dest_reg=7, w_data=32'hDEADBEEF,
//      d_rs2=7, d_rs2_data=0 -> e_rs2_data=32'hDEADBEEF.
//      Repeat with w_dest_reg=0, d_rs2=0 -> e_rs2_data=0.
//   6. Saturation: preload the counter near full and force 3 hazard bubbles starting
//      at 16'hFFFE -> counter reads FFFF and holds there.

Source files
------------

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   Decode-to-execute pipeline register for the 5-stage RV32 core.
//   Captures decoded operands/control, detects load-use hazards (stalling
//   fetch/decode and inserting a single bubble), applies the write-back bypass
//   to register-file read data, and counts load-use bubbles (saturating).
//   Reset is asynchronous and active-low on the 'reset' port.
// ----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              reset,

   // decode slot
   input  logic              d_valid,
   input  logic [XLEN-1:0]   d_pc,
   input  logic [4:0]        d_rs1,
   input  logic [4:0]        d_rs2,
   input  logic [4:0]        d_rd,
   input  logic              d_uses_rs1,
   input  logic              d_uses_rs2,
   input  logic [XLEN-1:0]   d_rs1_data,
   input  logic [XLEN-1:0]   d_rs2_data,
   input  logic [XLEN-1:0]   d_imm,
   input  logic              d_reg_write_enable,
   input  logic              d_mem_read,
   input  logic [CTRL_W-1:0] d_ctrl,

   // EX redirect
   input  logic              flush,

   // write-back port of the register file
   input  logic              w_reg_write_enable,
   input  logic [4:0]        w_dest_reg,
   input  logic [XLEN-1:0]   w_data,

   // outputs
   output logic              stall_fd,
   output logic              e_valid,
   output logic [XLEN-1:0]   e_pc,
   output logic [XLEN-1:0]   e_imm,
   output logic [4:0]        rs1_exe,
   output logic [4:0]        rs2_exe,
   output logic [4:0]        e_rd,
   output logic [XLEN-1:0]   e_rs1_data,
   output logic [XLEN-1:0]   e_rs2_data,
   output logic              e_reg_write_enable,
   output logic              e_mem_read,
   output logic [CTRL_W-1:0] e_ctrl,
   output logic [15:0]       load_use_stalls
);

   localparam logic [4:0]  REG_X0  = 5'd0;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;
   localparam logic [15:0] CNT_ONE = 16'h0001;

   // Write-back bypass: x0 is never bypassed, even if WB claims to write it.
   function automatic logic [XLEN-1:0] wb_bypass(
      input logic            wb_we,
      input logic [4:0]      wb_dst,
      input logic [XLEN-1:0] wb_data,
      input logic [4:0]      src,
      input logic [XLEN-1:0] rf_data
   );
      logic [XLEN-1:0] res;
      if (wb_we && (wb_dst != REG_X0) && (wb_dst == src)) begin
         res = wb_data;
      end else begin
         res = rf_data;
      end
      return res;
   endfunction

   // EX-stage registers
   logic              r_valid;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_imm;
   logic [4:0]        r_rs1;
   logic [4:0]        r_rs2;
   logic [4:0]        r_rd;
   logic [XLEN-1:0]   r_rs1_data;
   logic [XLEN-1:0]   r_rs2_data;
   logic              r_we;
   logic              r_mem_read;
   logic [CTRL_W-1:0] r_ctrl;
   logic [15:0]       r_lu_cnt;

   // combinational control
   logic              w_rs1_match;
   logic              w_rs2_match;
   logic              w_hazard;
   logic              w_stall;
   logic              w_bubble;
   logic              w_count;
   logic [XLEN-1:0]   w_rs1_byp;
   logic [XLEN-1:0]   w_rs2_byp;

   // Load-use hazard: a load in EX whose destination a valid decode slot reads.
   always_comb begin
      w_rs1_match = 1'b0;
      w_rs2_match = 1'b0;
      w_hazard    = 1'b0;
      if (d_valid && r_valid && r_mem_read && (r_rd != REG_X0)) begin
         w_rs1_match = d_uses_rs1 && (d_rs1 == r_rd);
         w_rs2_match = d_uses_rs2 && (d_rs2 == r_rd);
         w_hazard    = w_rs1_match || w_rs2_match;
      end else begin
         w_rs1_match = 1'b0;
         w_rs2_match = 1'b0;
         w_hazard    = 1'b0;
      end
   end

   // Stall/bubble decisions; a flush overrides the hazard and kills the slot.
   always_comb begin
      w_stall  = w_hazard & ~flush;
      w_bubble = w_hazard | flush;
      w_count  = w_stall;
   end

   // Per-source write-back bypass on the register-file read data.
   always_comb begin
      w_rs1_byp = wb_bypass(w_reg_write_enable, w_dest_reg, w_data, d_rs1, d_rs1_data);
      w_rs2_byp = wb_bypass(w_reg_write_enable, w_dest_reg, w_data, d_rs2, d_rs2_data);
   end

   // Control and index registers: cleared by a bubble, gated by d_valid on advance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid    <= 1'b0;
         r_we       <= 1'b0;
         r_mem_read <= 1'b0;
         r_rs1      <= 5'd0;
         r_rs2      <= 5'd0;
         r_rd       <= 5'd0;
         r_ctrl     <= {CTRL_W{1'b0}};
      end else if (w_bubble) begin
         r_valid    <= 1'b0;
         r_we       <= 1'b0;
         r_mem_read <= 1'b0;
         r_rs1      <= 5'd0;
         r_rs2      <= 5'd0;
         r_rd       <= 5'd0;
         r_ctrl     <= {CTRL_W{1'b0}};
      end else if (d_valid) begin
         r_valid    <= 1'b1;
         r_we       <= d_reg_write_enable;
         r_mem_read <= d_mem_read;
         r_rs1      <= d_rs1;
         r_rs2      <= d_rs2;
         r_rd       <= d_rd;
         r_ctrl     <= d_ctrl;
      end else begin
         r_valid    <= 1'b0;
         r_we       <= 1'b0;
         r_mem_read <= 1'b0;
         r_rs1      <= 5'd0;
         r_rs2      <= 5'd0;
         r_rd       <= 5'd0;
         r_ctrl     <= {CTRL_W{1'b0}};
      end
   end

   // Datapath registers: captured on advance, held across a bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc       <= {XLEN{1'b0}};
         r_imm      <= {XLEN{1'b0}};
         r_rs1_data <= {XLEN{1'b0}};
         r_rs2_data <= {XLEN{1'b0}};
      end else if (!w_bubble) begin
         r_pc       <= d_pc;
         r_imm      <= d_imm;
         r_rs1_data <= w_rs1_byp;
         r_rs2_data <= w_rs2_byp;
      end else begin
         r_pc       <= r_pc;
         r_imm      <= r_imm;
         r_rs1_data <= r_rs1_data;
         r_rs2_data <= r_rs2_data;
      end
   end

   // Saturating count of load-use bubbles; flush-only bubbles are not counted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lu_cnt <= 16'd0;
      end else if (w_count && (r_lu_cnt != CNT_MAX)) begin
         r_lu_cnt <= r_lu_cnt + CNT_ONE;
      end else begin
         r_lu_cnt <= r_lu_cnt;
      end
   end

   // Output mapping; stall_fd is intentionally combinational (same-cycle hold).
   assign stall_fd           = w_stall;
   assign e_valid            = r_valid;
   assign e_pc               = r_pc;
   assign e_imm              = r_imm;
   assign rs1_exe            = r_rs1;
   assign rs2_exe            = r_rs2;
   assign e_rd               = r_rd;
   assign e_rs1_data         = r_rs1_data;
   assign e_rs2_data         = r_rs2_data;
   assign e_reg_write_enable = r_we;
   assign e_mem_read         = r_mem_read;
   assign e_ctrl             = r_ctrl;
   assign load_use_stalls    = r_lu_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed-vector bench for id_ex_stage with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

   logic        clk;
   logic        reset;
   logic        d_valid;
   logic [31:0] d_pc;
   logic [4:0]  d_rs1, d_rs2, d_rd;
   logic        d_uses_rs1, d_uses_rs2;
   logic [31:0] d_rs1_data, d_rs2_data, d_imm;
   logic        d_reg_write_enable, d_mem_read;
   logic [7:0]  d_ctrl;
   logic        flush;
   logic        w_reg_write_enable;
   logic [4:0]  w_dest_reg;
   logic [31:0] w_data;
   logic        stall_fd, e_valid;
   logic [31:0] e_pc, e_imm;
   logic [4:0]  rs1_exe, rs2_exe, e_rd;
   logic [31:0] e_rs1_data, e_rs2_data;
   logic        e_reg_write_enable, e_mem_read;
   logic [7:0]  e_ctrl;
   logic [15:0] load_use_stalls;

   int errors = 0;
   int checks = 0;

   id_ex_stage #(.XLEN(32), .CTRL_W(8)) dut (
      .clk(clk), .reset(reset),
      .d_valid(d_valid), .d_pc(d_pc), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
      .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
      .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data), .d_imm(d_imm),
      .d_reg_write_enable(d_reg_write_enable), .d_mem_read(d_mem_read), .d_ctrl(d_ctrl),
      .flush(flush),
      .w_reg_write_enable(w_reg_write_enable), .w_dest_reg(w_dest_reg), .w_data(w_data),
      .stall_fd(stall_fd), .e_valid(e_valid), .e_pc(e_pc), .e_imm(e_imm),
      .rs1_exe(rs1_exe), .rs2_exe(rs2_exe), .e_rd(e_rd),
      .e_rs1_data(e_rs1_data), .e_rs2_data(e_rs2_data),
      .e_reg_write_enable(e_reg_write_enable), .e_mem_read(e_mem_read),
      .e_ctrl(e_ctrl), .load_use_stalls(load_use_stalls)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one rising edge and settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      d_valid = 1'b0; d_pc = 32'd0; d_rs1 = 5'd0; d_rs2 = 5'd0; d_rd = 5'd0;
      d_uses_rs1 = 1'b0; d_uses_rs2 = 1'b0; d_rs1_data = 32'd0; d_rs2_data = 32'd0;
      d_imm = 32'd0; d_reg_write_enable = 1'b0; d_mem_read = 1'b0; d_ctrl = 8'd0;
      flush = 1'b0; w_reg_write_enable = 1'b0; w_dest_reg = 5'd0; w_data = 32'd0;
   endtask

   // lw rd, imm(x1)
   task automatic drive_load(input logic [31:0] pc, input logic [4:0] rd);
      idle_inputs();
      d_valid = 1'b1; d_pc = pc; d_rd = rd; d_rs1 = 5'd1; d_uses_rs1 = 1'b1;
      d_reg_write_enable = 1'b1; d_mem_read = 1'b1; d_ctrl = 8'hA5; d_imm = 32'h10;
   endtask

   // add rd, rs1, rs2 (with selectable use flags)
   task automatic drive_add(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2, input logic [4:0] rd);
      idle_inputs();
      d_valid = 1'b1; d_pc = pc; d_rs1 = rs1; d_uses_rs1 = u1; d_rs2 = rs2; d_uses_rs2 = u2;
      d_rd = rd; d_reg_write_enable = 1'b1; d_ctrl = 8'h3C;
      d_rs1_data = 32'h0000_1111; d_rs2_data = 32'h0000_2222; d_imm = 32'h4;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      #12;
      chk("rst_valid", {31'd0, e_valid}, 32'd0);
      chk("rst_cnt", {16'd0, load_use_stalls}, 32'd0);
      chk("rst_stall", {31'd0, stall_fd}, 32'd0);
      reset = 1'b1;
      tick();

      // ---- load-use hazard ----
      drive_load(32'h100, 5'd5);
      tick();
      chk("lu_ex_mr", {31'd0, e_mem_read}, 32'd1);
      chk("lu_ex_rd", {27'd0, e_rd}, 32'd5);
      chk("lu_ex_ctrl", {24'd0, e_ctrl}, 32'hA5);
      drive_add(32'h104, 5'd5, 1'b1, 5'd6, 1'b0, 5'd7);
      #1;
      chk("lu_stall", {31'd0, stall_fd}, 32'd1);
      tick();
      chk("lu_bub_valid", {31'd0, e_valid}, 32'd0);
      chk("lu_bub_ctrl", {24'd0, e_ctrl}, 32'd0);
      chk("lu_bub_pc_hold", e_pc, 32'h100);
      chk("lu_cnt1", {16'd0, load_use_stalls}, 32'd1);
      chk("lu_stall_clr", {31'd0, stall_fd}, 32'd0);
      tick();
      chk("lu_adv_valid", {31'd0, e_valid}, 32'd1);
      chk("lu_adv_rs1", {27'd0, rs1_exe}, 32'd5);
      chk("lu_adv_pc", e_pc, 32'h104);
      chk("lu_adv_rd", {27'd0, e_rd}, 32'd7);
      chk("lu_adv_ctrl", {24'd0, e_ctrl}, 32'h3C);

      // ---- no false stall: rs1 not used ----
      drive_load(32'h200, 5'd5);
      tick();
      drive_add(32'h204, 5'd5, 1'b0, 5'd0, 1'b0, 5'd8);
      #1;
      chk("nf_unused_stall", {31'd0, stall_fd}, 32'd0);
      tick();
      chk("nf_unused_pc", e_pc, 32'h204);
      chk("nf_unused_cnt", {16'd0, load_use_stalls}, 32'd1);
      // load to x0
      drive_load(32'h300, 5'd0);
      tick();
      drive_add(32'h304, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9);
      #1;
      chk("nf_x0_stall", {31'd0, stall_fd}, 32'd0);
      tick();
      chk("nf_x0_pc", e_pc, 32'h304);
      // producer is not a load (EX holds add x9)
      drive_add(32'h308, 5'd9, 1'b1, 5'd9, 1'b1, 5'd10);
      #1;
      chk("nf_noload_stall", {31'd0, stall_fd}, 32'd0);
      tick();
      chk("nf_noload_pc", e_pc, 32'h308);
      chk("nf_noload_valid", {31'd0, e_valid}, 32'd1);

      // ---- flush during hazard ----
      drive_load(32'h400, 5'd5);
      tick();
      drive_add(32'h404, 5'd6, 1'b0, 5'd5, 1'b1, 5'd11);
      flush = 1'b1;
      #1;
      chk("fl_stall", {31'd0, stall_fd}, 32'd0);
      tick();
      chk("fl_valid", {31'd0, e_valid}, 32'd0);
      chk("fl_ctrl", {24'd0, e_ctrl}, 32'd0);
      chk("fl_rd", {27'd0, e_rd}, 32'd0);
      chk("fl_pc_hold", e_pc, 32'h400);
      chk("fl_cnt", {16'd0, load_use_stalls}, 32'd1);

      // ---- write-back bypass ----
      drive_add(32'h500, 5'd3, 1'b1, 5'd7, 1'b1, 5'd12);
      d_rs1_data = 32'h0000_1234; d_rs2_data = 32'd0;
      w_reg_write_enable = 1'b1; w_dest_reg = 5'd7; w_data = 32'hDEADBEEF;
      tick();
      chk("byp_rs2", e_rs2_data, 32'hDEADBEEF);
      chk("byp_rs1_nomatch", e_rs1_data, 32'h0000_1234);
      drive_add(32'h504, 5'd7, 1'b1, 5'd0, 1'b1, 5'd13);
      d_rs1_data = 32'h0000_5555; d_rs2_data = 32'd0;
      w_reg_write_enable = 1'b1; w_dest_reg = 5'd0; w_data = 32'hDEADBEEF;
      tick();
      chk("byp_x0", e_rs2_data, 32'd0);
      chk("byp_rs1_x0w", e_rs1_data, 32'h0000_5555);

      // ---- invalid decode slot advances with control forced off ----
      drive_add(32'h600, 5'd4, 1'b1, 5'd4, 1'b1, 5'd14);
      d_valid = 1'b0; d_mem_read = 1'b1;
      tick();
      chk("inv_valid", {31'd0, e_valid}, 32'd0);
      chk("inv_we", {31'd0, e_reg_write_enable}, 32'd0);
      chk("inv_mr", {31'd0, e_mem_read}, 32'd0);
      chk("inv_rd", {27'd0, e_rd}, 32'd0);
      chk("inv_pc", e_pc, 32'h600);

      // ---- saturation ----
      force dut.r_lu_cnt = 16'hFFFE;
      #1;
      release dut.r_lu_cnt;
      #1;
      chk("sat_preload", {16'd0, load_use_stalls}, 32'h0000FFFE);
      for (int i = 0; i < 3; i++) begin
         drive_load(32'h700 + 32'(i * 8), 5'd5);
         tick();
         drive_add(32'h704 + 32'(i * 8), 5'd5, 1'b1, 5'd0, 1'b0, 5'd15);
         tick();
         chk("sat_cnt", {16'd0, load_use_stalls}, 32'h0000FFFF);
      end

      // ---- reset asserted mid-stall ----
      drive_load(32'h800, 5'd5);
      tick();
      drive_add(32'h804, 5'd5, 1'b1, 5'd0, 1'b0, 5'd16);
      #1;
      chk("mr_pre_stall", {31'd0, stall_fd}, 32'd1);
      #1;
      reset = 1'b0;
      #1;
      chk("mr_valid", {31'd0, e_valid}, 32'd0);
      chk("mr_stall", {31'd0, stall_fd}, 32'd0);
      chk("mr_pc", e_pc, 32'd0);
      chk("mr_imm", e_imm, 32'd0);
      chk("mr_rd", {27'd0, e_rd}, 32'd0);
      chk("mr_mr", {31'd0, e_mem_read}, 32'd0);
      chk("mr_ctrl", {24'd0, e_ctrl}, 32'd0);
      chk("mr_data", e_rs1_data | e_rs2_data, 32'd0);
      chk("mr_idx", {22'd0, rs1_exe, rs2_exe}, 32'd0);
      chk("mr_cnt", {16'd0, load_use_stalls}, 32'd0);
      #1;
      reset = 1'b1;
      tick();
      chk("mr_adv_valid", {31'd0, e_valid}, 32'd1);
      chk("mr_adv_pc", e_pc, 32'h804);
      chk("mr_adv_rs1", {27'd0, rs1_exe}, 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
